// File: rtl/aes_sbox_engine_128.sv
// aes_sbox_engine_128
//   Time-multiplexed AES byte-substitution engine. One 128-bit state is
//   accepted per transaction and pushed through LANES S-box lanes over
//   PASSES = 16/LANES passes, forward (SubBytes) or inverse (InvSubBytes)
//   as selected at accept time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream offers a state
//   in_ready   engine accepts a state this cycle
//   in_inv     0 = forward S-box, 1 = inverse S-box (sampled at accept)
//   in_data    input state, byte i = in_data[8i+7:8i]
//   out_valid  result available
//   out_ready  downstream takes the result
//   out_data   substituted state (holds last result outside DONE)
//   busy       high while passes are running
//
// Build option
//   AES_SBOX_PIPE_EN  registers the lane lookups before write-back; each
//                     pass then takes two cycles (latency 2*PASSES).
module aes_sbox_engine_128 #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned PASSES = 16 / LANES;
    localparam int unsigned CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("aes_sbox_engine_128: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [127:0]         work_q;
    logic [127:0]         work_d;
    logic [127:0]         out_q;
    logic                 mode_q;
    logic                 out_valid_q;
    logic [LANES*8-1:0]   lane_vec;
    logic [LANES*8-1:0]   lane_out;
    logic [LANES*8-1:0]   wr_lanes;
    logic                 commit;
    logic                 last_pass;
    logic                 accept;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), square-and-multiply
    // over the exponent bits 1111_1110 from the MSB down.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            r = gf_mul(r, r);
            if (i < 7) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // One inversion per lane is shared by both directions:
    // forward = affine(inv(x)), inverse = inv(inv_affine(x)).
    function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        pre = inv ? (rotl(x, 6) ^ rotl(x, 3) ^ rotl(x, 1) ^ 8'h05) : x;
        g   = gf_inv(pre);
        return inv ? g : (g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63);
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == BUSY);
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign last_pass = (cnt_q == CW'(PASSES - 1));

    // Bytes for the current pass, selected by the pass counter
    if (PASSES == 1) begin : g_sel_all
        assign lane_vec = work_q;
    end else begin : g_sel_pass
        logic [LANES*8-1:0] slice [PASSES];
        for (genvar p = 0; p < PASSES; p++) begin : g_slice
            assign slice[p] = work_q[p*LANES*8 +: LANES*8];
        end
        assign lane_vec = slice[cnt_q];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_out[8*l +: 8] = sub_byte(lane_vec[8*l +: 8], mode_q);
    end

`ifdef AES_SBOX_PIPE_EN
    logic               phase_q;
    logic [LANES*8-1:0] stage_q;
    assign wr_lanes = stage_q;
    assign commit   = phase_q;
`else
    assign wr_lanes = lane_out;
    assign commit   = 1'b1;
`endif

    // In-place write-back of the current pass into the work register
    for (genvar b = 0; b < 16; b++) begin : g_wr
        assign work_d[8*b +: 8] = (cnt_q == CW'(b / LANES)) ? wr_lanes[8*(b % LANES) +: 8]
                                                            : work_q[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_SBOX_PIPE_EN
            phase_q     <= 1'b0;
            stage_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                end
                BUSY: begin
`ifdef AES_SBOX_PIPE_EN
                    phase_q <= ~phase_q;
                    if (!phase_q) stage_q <= lane_out;
`endif
                    if (commit) begin
                        work_q <= work_d;
                        if (last_pass) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_q       <= work_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Accept overrides the DONE->IDLE return to give back-to-back
            if (accept) begin
                work_q  <= in_data;
                mode_q  <= in_inv;
                cnt_q   <= '0;
                state_q <= BUSY;
`ifdef AES_SBOX_PIPE_EN
                phase_q <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox_engine_128.sv
module tb_aes_sbox_engine_128;

    localparam int unsigned LANES  = 4;
    localparam int unsigned PASSES = 16 / LANES;
`ifdef AES_SBOX_PIPE_EN
    localparam int LAT = 2 * PASSES;
`else
    localparam int LAT = PASSES;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    aes_sbox_engine_128 #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference S-boxes from exp/log tables over generator 3 and the affine
    // map as a matrix of row parities; inverse table by inverting forward.
    function automatic logic [7:0] affine_m(input logic [7:0] b);
        logic [7:0]  r;
        logic [15:0] t;
        logic [7:0]  c;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            t    = {8'hF1, 8'hF1} << i;
            r[i] = (^(b & t[15:8])) ^ c[i];
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] x;
        logic [7:0] iv;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
        end
        for (int v = 0; v < 256; v++) begin
            iv = (v == 0) ? 8'h00 : ex[(255 - lg[v]) % 255];
            sb[v] = affine_m(iv);
        end
        for (int v = 0; v < 256; v++) isb[sb[v]] = 8'(v);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            r[8*i +: 8] = inv ? isb[b] : sb[b];
        end
        return r;
    endfunction

    // Called right after a negedge; presents a state, checks in_ready,
    // lets the accept edge pass and returns at the following negedge.
    task automatic send(input logic [127:0] d, input logic inv, input logic with_ready);
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = inv;
        out_ready = with_ready;
        #1;
        check_eq("in_ready_at_accept", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic collect(input logic [127:0] exp, input int hold, input logic release_it,
                           output logic [127:0] got);
        int k;
        k = 0;
        while (!out_valid && k < 400) begin
            check_eq("busy_while_running", 128'(busy), 128'(1'b1));
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_inv  = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        check_eq("latency", 128'(k), 128'(LAT));
        check_eq("result", out_data, exp);
        got = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_data", out_data, exp);
            check_eq("hold_in_ready", 128'(in_ready), 128'(1'b0));
            check_eq("hold_valid", 128'(out_valid), 128'(1'b1));
        end
        if (release_it) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("valid_clear", 128'(out_valid), 128'(1'b0));
        end
    endtask

    logic [127:0] kat_in  [6];
    logic         kat_inv [6];
    logic [127:0] kat_out [6];

    initial begin
        logic [127:0] got;
        logic [127:0] d;
        logic         inv;
        logic         pending;
        logic         rel;
        int           hold;

        build_tables();
        kat_in[0] = '0;                                      kat_inv[0] = 1'b0;
        kat_out[0] = {16{8'h63}};
        kat_in[1] = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;  kat_inv[1] = 1'b0;
        kat_out[1] = 128'h3052411ee55db4b8f198bfe0ae1127d4;
        kat_in[2] = 128'h3052411ee55db4b8f198bfe0ae1127d4;  kat_inv[2] = 1'b1;
        kat_out[2] = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
        kat_in[3] = '0;                                      kat_inv[3] = 1'b1;
        kat_out[3] = {16{8'h52}};
        kat_in[4] = {16{8'h63}};                             kat_inv[4] = 1'b1;
        kat_out[4] = '0;
        kat_in[5] = {16{8'h53}};                             kat_inv[5] = 1'b0;
        kat_out[5] = {16{8'hed}};

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_busy", 128'(busy), 128'(1'b0));

        for (int i = 0; i < 6; i++) begin
            send(kat_in[i], kat_inv[i], 1'b0);
            collect(model(kat_in[i], kat_inv[i]), 0, 1'b1, got);
            check_eq($sformatf("kat%0d", i), got, kat_out[i]);
        end

        // Stall in DONE, then release and accept on the same edge
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, 1'b0);
        collect(model(d, 1'b0), 5, 1'b0, got);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b1, 1'b1);
        check_eq("b2b_valid_drop", 128'(out_valid), 128'(1'b0));
        collect(model(d, 1'b1), 0, 1'b1, got);

        // Reset in the middle of a transaction
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        check_eq("midrst_out_data", out_data, '0);
        check_eq("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("midrst_busy", 128'(busy), 128'(1'b0));
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b1, 1'b0);
        collect(model(d, 1'b1), 0, 1'b1, got);

        // Random traffic with random stalls and back-to-back handoffs
        pending = 1'b0;
        for (int t = 0; t < 24; t++) begin
            d    = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv  = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            rel  = 1'($urandom_range(0, 1));
            send(d, inv, pending);
            collect(model(d, inv), hold, rel, got);
            pending = !rel;
        end
        if (pending) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("final_valid_clear", 128'(out_valid), 128'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sbox_engine_128.md
Name: aes_sbox_engine_128

Overview:
- Time-multiplexed, parametrised AES byte-substitution engine for one 128-bit state per transaction.
- Applies the forward S-box (SubBytes) or the inverse S-box (InvSubBytes), selected per transaction.
- Uses LANES byte S-box pairs and processes the state in 16/LANES passes.
- Sits between the round-key/shift stages and the mix stages of the iterative cipher/decipher datapath, with valid/ready handshakes on both sides.

Parameters:
- LANES, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16. Any other value is a compile-time error.
- PASSES, 16/LANES, derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has a state to substitute
- in_ready  output  1  engine can accept a state this cycle
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept
- in_data  input  128  state; byte i = in_data[8i+7:8i]
- out_valid  output  1  result is available
- out_ready  input  1  downstream takes the result
- out_data  output  128  substituted state; byte i maps from input byte i
- busy  output  1  high in BUSY

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - FSM=IDLE, pass counter=0.
  - Reset mid-transaction discards all work; the next cycle behaves as after power-up reset.
- FSM states: IDLE, BUSY, DONE.
- Accept: an accept occurs on the edge where in_valid && in_ready.
  - in_data is copied into the work register and in_inv into the mode register.
  - The pass counter is cleared and the FSM goes to BUSY.
  - in_data and in_inv changes after the accept are ignored.
- BUSY:
  - Pass p (0..PASSES-1) substitutes bytes p*LANES .. p*LANES+LANES-1 of the work register in place, using the latched mode.
  - The counter increments each cycle.
  - On the edge that completes pass PASSES-1, the FSM goes to DONE and out_valid is set.
  - Latency from the accepting edge to out_valid visible is PASSES cycles (LANES=16 gives 1; LANES=4 gives 4; LANES=1 gives 16).
- DONE:
  - out_data holds the full result and out_valid=1.
  - out_data is stable while out_valid && !out_ready.
  - On out_ready: out_valid clears and the FSM returns to IDLE.
  - Back-to-back: if in_valid is also high in that same cycle, the new state is accepted and the FSM goes to BUSY directly, with no idle bubble.
- in_ready = (FSM==IDLE) || (FSM==DONE && out_ready). It is never high in BUSY.
- out_data in IDLE/BUSY:
  - It holds the last completed result (0 after reset).
  - In-progress passes are never exposed; the work register is separate from the output register.
- busy = (FSM==BUSY).
- S-box content is the standard FIPS-197 tables, implemented as combinational per-lane lookups. The mux selects forward or inverse output per the latched mode.
- No overflow or underflow is possible: the engine has a single slot and upstream is back-pressured by in_ready.

Optional Feature:
- Macro: AES_SBOX_PIPE_EN.
- Defined:
  - A register stage is inserted between the lane lookups and the work-register write.
  - Each pass takes 2 cycles (lookup, writeback), and the counter advances every other cycle.
  - Latency becomes 2*PASSES cycles.
  - Handshake rules and the DONE/back-to-back behaviour are unchanged.
- Undefined: single-cycle passes, latency PASSES as above.

Test Plan:
- LANES=4, reset then accept in_data=0, in_inv=0 -> out_valid rises exactly 4 cycles after accept; out_data=0x6363...63 (all 16 bytes 0x63).
- Forward FIPS-197 Appendix B, round 1: in_data bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> out bytes d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30. Then feed that result back with in_inv=1 -> the original state is returned.
- Inverse of all-zero state -> all bytes 0x52; byte 0x63 inverse -> 0x00; byte 0x53 forward -> 0xED.
- Hold out_ready=0 for 5 cycles in DONE:
  - out_data stable and in_ready=0 throughout.
  - Then raise out_ready with in_valid=1 and a new state: both handshakes complete on the same edge, and the next result arrives PASSES cycles later.
- Toggle in_inv and in_data during BUSY -> result reflects only the values sampled at accept.
- Assert rst for 1 cycle mid-BUSY (pass 2 of 4) -> next cycle out_valid=0, out_data=0, in_ready=1, busy=0. A subsequent transaction completes correctly.
- Regress with LANES=1 and LANES=16 (latency 16 and 1), with and without AES_SBOX_PIPE_EN (latency doubled).
